// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops, iterative MUL/DIVU/REMU,
// registered result and flags with a valid/ready handshake on both sides.
module seq_alu #(
    parameter int WIDTH = 32,
    localparam int SH_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] op_0,
    input  logic [WIDTH-1:0] op_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    logic             accept;
    logic             iter_op;
    logic             last;
    logic             load;
    logic [3:0]       opc_q;
    logic [SH_W-1:0]  cnt;
    logic [WIDTH-1:0] acc, x, y;
    logic [WIDTH-1:0] acc_n, x_n, y_n;
    logic [WIDTH-1:0] it_val;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH:0]   sum, dif;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] sc_val;
    logic             sc_c, sc_v, sc_ill;
    logic [WIDTH-1:0] ld_val;
    logic             ld_c, ld_v, ld_ill;

    assign accept  = in_valid & in_ready;
    assign iter_op = (opcode == 4'd8) | (opcode == 4'd9) | (opcode == 4'd10);
    assign last    = &cnt;
    assign load    = (accept & ~iter_op) | ((state == BUSY) & last);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = iter_op ? BUSY : DONE;
            BUSY:    if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Single-cycle ops evaluate straight from the accepted inputs so the result
    // lands in the output register on the accept edge.
    always_comb begin
        sum    = {1'b0, op_0} + {1'b0, op_1};
        dif    = {1'b0, op_0} - {1'b0, op_1};
        shamt  = op_1[SH_W-1:0];
        sc_val = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_ill = 1'b0;
        case (opcode)
            4'd0: begin
                sc_val = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (op_0[WIDTH-1] == op_1[WIDTH-1]) && (sum[WIDTH-1] != op_0[WIDTH-1]);
            end
            4'd1: begin
                sc_val = dif[WIDTH-1:0];
                sc_c   = ~dif[WIDTH];
                sc_v   = (op_0[WIDTH-1] != op_1[WIDTH-1]) && (dif[WIDTH-1] != op_0[WIDTH-1]);
            end
            4'd2:    sc_val = op_0 & op_1;
            4'd3:    sc_val = op_0 | op_1;
            4'd4:    sc_val = op_0 ^ op_1;
            4'd5:    sc_val = op_0 << shamt;
            4'd6:    sc_val = op_0 >> shamt;
            4'd7:    sc_val = $signed(op_0) >>> shamt;
            default: sc_ill = 1'b1;
        endcase
    end

    // One radix-2 step: shift-add for MUL, restoring subtract for DIVU/REMU.
    // With a zero divisor every trial succeeds, giving all-ones quotient and rem = op_0.
    always_comb begin
        rem_sh = {acc, x[WIDTH-1]};
        trial  = rem_sh - {1'b0, y};
        acc_n  = acc;
        x_n    = x;
        y_n    = y;
        it_val = '0;
        if (opc_q == 4'd8) begin
            acc_n  = acc + (y[0] ? x : '0);
            x_n    = x << 1;
            y_n    = y >> 1;
            it_val = acc_n;
        end else begin
            if (!trial[WIDTH]) begin
                acc_n = trial[WIDTH-1:0];
                x_n   = {x[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = rem_sh[WIDTH-1:0];
                x_n   = {x[WIDTH-2:0], 1'b0};
            end
            it_val = (opc_q == 4'd9) ? x_n : acc_n;
        end
    end

    always_comb begin
        if (state == BUSY) begin
            ld_val = it_val;
            ld_c   = 1'b0;
            ld_v   = 1'b0;
            ld_ill = 1'b0;
        end else begin
            ld_val = sc_val;
            ld_c   = sc_c;
            ld_v   = sc_v;
            ld_ill = sc_ill;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            opc_q    <= '0;
            cnt      <= '0;
            acc      <= '0;
            x        <= '0;
            y        <= '0;
            out      <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            if (accept) begin
                opc_q <= opcode;
                cnt   <= '0;
                acc   <= '0;
                x     <= op_0;
                y     <= op_1;
            end
            if (state == BUSY) begin
                acc <= acc_n;
                x   <= x_n;
                y   <= y_n;
                cnt <= cnt + SH_W'(1);
            end
            if (load) begin
                out      <= ld_val;
                zero     <= (ld_val == '0);
                negative <= ld_val[WIDTH-1];
                carry    <= ld_c;
                overflow <= ld_v;
                illegal  <= ld_ill;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus random operations
// compared against an arithmetic reference model; a WIDTH=8 instance covers scaling.
module tb_seq_alu;

    logic        clock;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  opcode;
    logic [31:0] op_0, op_1, out;
    logic        zero, negative, carry, overflow, illegal;

    logic        iv8, ir8, ov8, or8;
    logic [3:0]  opc8;
    logic [7:0]  a8, b8, out8;
    logic        z8, n8, c8, v8, il8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] r;
        logic [4:0]  f;
    } res_t;

    seq_alu #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .op_0(op_0), .op_1(op_1), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .zero(zero), .negative(negative),
        .carry(carry), .overflow(overflow), .illegal(illegal)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .opcode(opc8), .op_0(a8), .op_1(b8), .out_valid(ov8),
        .out_ready(or8), .out(out8), .zero(z8), .negative(n8),
        .carry(c8), .overflow(v8), .illegal(il8)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(int w, logic [3:0] op, longint unsigned a_in, longint unsigned b_in);
        res_t m;
        longint unsigned mask, a, b, r, full, wl;
        int sh;
        logic c, v, ill, sa, sb, sr;
        mask = (64'd1 << w) - 64'd1;
        a = a_in & mask;
        b = b_in & mask;
        wl = longint'(w);
        sh = int'(b % wl);
        sa = ((a >> (w - 1)) & 64'd1) != 0;
        sb = ((b >> (w - 1)) & 64'd1) != 0;
        c = 0; v = 0; ill = 0; r = 0;
        case (op)
            4'd0: begin
                full = a + b;
                r = full & mask;
                c = ((full >> w) & 64'd1) != 0;
                sr = ((r >> (w - 1)) & 64'd1) != 0;
                v = (sa == sb) && (sr != sa);
            end
            4'd1: begin
                r = (a - b) & mask;
                c = (a >= b);
                sr = ((r >> (w - 1)) & 64'd1) != 0;
                v = (sa != sb) && (sr != sa);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = (a << sh) & mask;
            4'd6: r = a >> sh;
            4'd7: r = sa ? ((a >> sh) | (mask & ~(mask >> sh))) : (a >> sh);
            4'd8: r = (a * b) & mask;
            4'd9: r = (b == 0) ? mask : a / b;
            4'd10: r = (b == 0) ? a : a % b;
            default: ill = 1;
        endcase
        m.r = r;
        m.f = {r == 0, ((r >> (w - 1)) & 64'd1) != 0, c, v, ill};
        return m;
    endfunction

    // Issues one request on the 32-bit instance and checks it; leaves the DUT in DONE.
    task automatic run32(input string tag, input logic [3:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_out,
                         input logic [4:0] exp_flags, input int exp_lat);
        int lat;
        logic ready_bad;
        chk({tag, ".ready_in"}, in_ready, 1'b1);
        in_valid = 1'b1; opcode = opc; op_0 = a; op_1 = b;
        @(posedge clock); #1;
        in_valid = 1'b0; opcode = 4'($urandom); op_0 = $urandom; op_1 = $urandom;
        lat = 1;
        ready_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_bad = 1'b1;
            @(posedge clock); #1;
            lat++;
        end
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".out"}, out, exp_out);
        chk({tag, ".flags"}, {zero, negative, carry, overflow, illegal}, exp_flags);
        if (exp_lat > 1) chk({tag, ".busy_ready"}, ready_bad, 1'b0);
    endtask

    task automatic release32();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        res_t m;
        logic [3:0]  ropc;
        logic [31:0] ra, rb, held_out;
        logic [4:0]  held_flags;
        logic        saw_valid;
        int          lat;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = '0; op_0 = '0; op_1 = '0;
        iv8 = 1'b0; or8 = 1'b0; opc8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        chk("rst.out", out, 32'h0);
        chk("rst.flags", {zero, negative, carry, overflow, illegal}, 5'b00000);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);

        run32("add_ovf", 4'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 5'b01010, 1);
        release32();
        run32("sub_eq", 4'd1, 32'd5, 32'd5, 32'h0, 5'b10100, 1);
        release32();
        run32("sra", 4'd7, 32'h80000000, 32'h24, 32'hF8000000, 5'b01000, 1);
        release32();
        run32("mul", 4'd8, 32'h10000, 32'h10001, 32'h00010000, 5'b00000, 33);
        release32();
        run32("divu0", 4'd9, 32'd100, 32'd0, 32'hFFFFFFFF, 5'b01000, 33);
        release32();
        run32("remu", 4'd10, 32'd100, 32'd7, 32'd2, 5'b00000, 33);
        release32();
        run32("illegal", 4'd12, 32'h1234, 32'h5678, 32'h0, 5'b10001, 1);
        release32();

        // Held result must stay put while the consumer stalls; requests are ignored.
        run32("hold", 4'd4, 32'hA5A5F00F, 32'h0FF0FFFF, 32'hAA550FF0, 5'b01000, 1);
        held_out = out;
        held_flags = {zero, negative, carry, overflow, illegal};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom); opcode = 4'($urandom); op_0 = $urandom; op_1 = $urandom;
            @(posedge clock); #1;
            chk("hold.out", out, 32'hAA550FF0);
            chk("hold.flags", {zero, negative, carry, overflow, illegal}, 5'b01000);
            chk("hold.valid", out_valid, 1'b1);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("release.in_ready", in_ready, 1'b1);
        chk("release.out_valid", out_valid, 1'b0);
        @(posedge clock); #1;
        chk("bubble.no_accept", {in_ready, out_valid}, 2'b10);
        chk("hold.kept", {held_out, held_flags}, {out, zero, negative, carry, overflow, illegal});

        for (int t = 0; t < 40; t++) begin
            ropc = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 4) == 0) ? 32'h80000000 >> $urandom_range(0, 31) : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            m = model(32, ropc, {32'h0, ra}, {32'h0, rb});
            run32("rnd", ropc, ra, rb, m.r[31:0], m.f,
                  (ropc >= 4'd8 && ropc <= 4'd10) ? 33 : 1);
            release32();
        end

        // Reset in the tenth BUSY cycle of a division abandons it.
        in_valid = 1'b1; opcode = 4'd9; op_0 = 32'd1000; op_1 = 32'd3;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("busy_rst.in_ready", in_ready, 1'b1);
        chk("busy_rst.out_valid", out_valid, 1'b0);
        chk("busy_rst.out", out, 32'h0);
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        chk("busy_rst.no_pulse", saw_valid, 1'b0);

        iv8 = 1'b1; opc8 = 4'd8; a8 = 8'h10; b8 = 8'h11;
        @(posedge clock); #1;
        iv8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        lat = 1;
        while (!ov8 && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("w8_mul.lat", lat, 9);
        chk("w8_mul.out", out8, 8'h10);
        chk("w8_mul.flags", {z8, n8, c8, v8, il8}, 5'b00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits (>= 8, power of two).
REQ-002 Parameter: SH_W, $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  request present.
REQ-006 Port: in_ready  output  1  block can accept a request.
REQ-007 Port: opcode  input  4  operation select.
REQ-008 Port: op_0  input  WIDTH  first operand.
REQ-009 Port: op_1  input  WIDTH  second operand / shift amount.
REQ-010 Port: out_valid  output  1  result present.
REQ-011 Port: out_ready  input  1  consumer accepts result.
REQ-012 Port: out  output  WIDTH  result.
REQ-013 Port: zero, negative, carry, overflow  output  1 each  flags of held result.
REQ-014 Port: illegal  output  1  held result came from an undefined opcode.

Function
REQ-015 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA (single-cycle); 8 MUL, 9 DIVU, 10 REMU (iterative); 11-15 illegal.
REQ-016 FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-017 Request accepted on edge with in_valid & in_ready; opcode/operands captured into internal registers; later input changes ignored.
REQ-018 IDLE + accept of opcode 0-7 or 11-15 -> DONE; out_valid asserts next cycle (latency 1).
REQ-019 IDLE + accept of opcode 8-10 -> BUSY; one radix-2 step per cycle for exactly WIDTH cycles, then DONE (out_valid latency WIDTH+1 from accept).
REQ-020 DONE: out, flags, illegal held stable while out_valid=1 and out_ready=0.
REQ-021 DONE & out_ready -> IDLE; out_valid deasserts next cycle; no new accept in that same cycle (one bubble).
REQ-022 Shifts use op_1[SH_W-1:0] only; SRA sign-fills from op_0[WIDTH-1].
REQ-023 MUL: low WIDTH bits of unsigned product (shift-add).
REQ-024 DIVU/REMU: unsigned restoring division; op_1 = 0 -> DIVU result all-ones, REMU result = op_0; still WIDTH cycles.
REQ-025 Illegal opcode: out = 0, illegal = 1, zero = 1, other flags 0.
REQ-026 zero = (out == 0); negative = out[WIDTH-1]; both valid for every opcode.
REQ-027 ADD: carry = carry-out of op_0+op_1; overflow = signed overflow.
REQ-028 SUB: carry = 1 iff op_0 >= op_1 unsigned (no borrow); overflow = signed overflow.
REQ-029 carry = overflow = 0 for all opcodes other than ADD/SUB.
REQ-030 Flags and illegal registered with out; no combinational path from inputs to any output except none (all outputs registered or state-decoded).

Reset
REQ-031 reset=1 at an edge: state -> IDLE; out, flags, illegal, out_valid -> 0; in_ready = 1 the following cycle.
REQ-032 reset has priority over accept and over iteration; reset during BUSY or DONE abandons the operation with no out_valid pulse.
REQ-033 No initial blocks; behaviour before first reset undefined.

Verification
REQ-034 WIDTH=32, ADD 0x7FFFFFFF+1 -> out 0x80000000, negative=1, overflow=1, carry=0, out_valid 1 cycle after accept.
REQ-035 SUB 5-5 -> out 0, zero=1, carry=1; SRA 0x80000000 by op_1=0x24 (shamt 4) -> 0xF8000000.
REQ-036 MUL 0x10000 x 0x10001 -> out 0x00010000 exactly 33 cycles after accept; in_ready=0 throughout.
REQ-037 DIVU 100/0 -> 0xFFFFFFFF; REMU 100/7 -> 2; opcode 12 -> out 0, illegal=1, zero=1.
REQ-038 out_ready held 0 for 5 cycles in DONE -> out/flags stable; in_valid pulses ignored; release -> in_ready returns next cycle.
REQ-039 reset asserted in BUSY cycle 10 of DIVU -> next cycle IDLE, out_valid=0, out=0; WIDTH=8 rerun of REQ-036 pattern scaled (0x10 x 0x11 -> 0x10, 9 cycles).
